// File: rtl/matmul_ctrl.sv
// Host-side sequencer for a matrix-multiply core: loads A and B from an element
// stream, pulses start, waits for done, then streams the captured C back out.
module matmul_ctrl #(
  parameter int mat_size = 2,
  parameter int dat_size = 8,
  parameter int timeout  = 256
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [dat_size-1:0]                              in_data,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [dat_size-1:0]                              out_data,
  output logic                                             busy,
  output logic                                             err,
  output logic                                             start,
  input  logic                                             done,
  output logic [mat_size-1:0][mat_size-1:0][dat_size-1:0]  mat_A,
  output logic [mat_size-1:0][mat_size-1:0][dat_size-1:0]  mat_B,
  input  logic [mat_size-1:0][mat_size-1:0][dat_size-1:0]  mat_C
);

  localparam int IW = (mat_size > 1) ? $clog2(mat_size) : 1;
  localparam int TW = $clog2(timeout + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(mat_size - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(timeout - 1);

  typedef logic [mat_size-1:0][mat_size-1:0][dat_size-1:0] mat_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       row_q, row_d, col_q, col_d;
  logic [IW-1:0]       row_inc_s, col_inc_s;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  mat_t                a_q, a_d, b_q, b_d, c_q, c_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [dat_size-1:0] out_data_q, out_data_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                start_q, start_d;
  logic                in_fire_s, out_fire_s, last_s;

  assign in_fire_s  = in_valid && in_ready_q;
  assign out_fire_s = out_valid_q && out_ready;
  assign last_s     = (row_q == LAST_IDX) && (col_q == LAST_IDX);

  // Row-major successor of the current element position.
  always_comb begin
    if (col_q == LAST_IDX) begin
      col_inc_s = '0;
      row_inc_s = row_q + 1'b1;
    end else begin
      col_inc_s = col_q + 1'b1;
      row_inc_s = row_q;
    end
  end

  // Next-state logic and matrix register updates.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tcnt_d  = tcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire_s) begin
          a_d[row_q][col_q] = in_data;
          err_d   = 1'b0;
          row_d   = row_inc_s;
          col_d   = col_inc_s;
          state_d = S_LOAD_A;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_A: begin
        if (in_fire_s) begin
          a_d[row_q][col_q] = in_data;
          if (last_s) begin
            row_d   = '0;
            col_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            row_d = row_inc_s;
            col_d = col_inc_s;
          end
        end else begin
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_B: begin
        if (in_fire_s) begin
          b_d[row_q][col_q] = in_data;
          if (last_s) begin
            row_d   = '0;
            col_d   = '0;
            state_d = S_START;
          end else begin
            row_d = row_inc_s;
            col_d = col_inc_s;
          end
        end else begin
          state_d = S_LOAD_B;
        end
      end
      S_START: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done level in the first WAIT cycle may be stale from the previous run.
        if ((tcnt_q != '0) && done) begin
          c_d     = mat_C;
          row_d   = '0;
          col_d   = '0;
          state_d = S_DRAIN;
        end else if (tcnt_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_fire_s) begin
          if (last_s) begin
            row_d   = '0;
            col_d   = '0;
            state_d = S_IDLE;
          end else begin
            row_d = row_inc_s;
            col_d = col_inc_s;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        row_d   = '0;
        col_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    out_valid_d = (state_d == S_DRAIN);
    busy_d      = (state_d != S_IDLE);
    start_d     = (state_d == S_START);
    if (state_d == S_DRAIN) begin
      out_data_d = c_d[row_d][col_d];
    end else begin
      out_data_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      tcnt_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      tcnt_q      <= tcnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      start_q     <= start_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign start     = start_q;
  assign mat_A     = a_q;
  assign mat_B     = b_q;

endmodule
